// File: rtl/ladybird_gpio_pkg.sv
// Shared constants for the ladybird GPIO controller: register offsets, maximum
// pin width and a byte-strobe expansion helper.
package ladybird_gpio_pkg;

   localparam int GPIO_MAX_WIDTH = 32;

   localparam logic [4:0] ADDR_IN       = 5'h00;
   localparam logic [4:0] ADDR_OUT      = 5'h04;
   localparam logic [4:0] ADDR_OUT_SET  = 5'h08;
   localparam logic [4:0] ADDR_OUT_CLR  = 5'h0C;
   localparam logic [4:0] ADDR_RISE_EN  = 5'h10;
   localparam logic [4:0] ADDR_FALL_EN  = 5'h14;
   localparam logic [4:0] ADDR_STATUS   = 5'h18;
   localparam logic [4:0] ADDR_INTERVAL = 5'h1C;

   // Each strobe bit enables one 8-bit lane of the 32-bit write word.
   function automatic logic [GPIO_MAX_WIDTH-1:0] strbToMask(input logic [3:0] strb);
      logic [GPIO_MAX_WIDTH-1:0] mask;
      for (int k = 0; k < 4; k++) begin
         mask[8*k +: 8] = {8{strb[k]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/ladybird_bus.sv
// Simple request/grant register bus; the secondary side answers reads on the
// shared data lines in the same cycle.
interface ladybird_bus;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        data_gnt;
   logic [31:0] data;

   modport primary (
      output req, addr, wstrb, wdata,
      input  gnt, data_gnt, data
   );

   modport secondary (
      input  req, addr, wstrb, wdata,
      output gnt, data_gnt, data
   );
endinterface

// File: rtl/ladybird_gpio_debounce.sv
// One input pin: two-flop synchroniser followed by a tick-sampled two-stage
// debouncer that reports rising/falling edges of the debounced level.
module ladybird_gpio_debounce (
   input  logic clk,
   input  logic arst,
   input  logic i_pin,
   input  logic i_tick,
   input  logic i_primed,
   output logic o_deb,
   output logic o_rise,
   output logic o_fall
);

   logic r_sync1;
   logic r_sync2;
   logic r_cand;
   logic r_deb;
   logic w_debNext;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cand  <= 1'b0;
         r_deb   <= 1'b0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         if (i_tick) begin
            r_cand <= r_sync2;
            r_deb  <= w_debNext;
         end
      end
   end

   // Before priming the level is adopted blindly so reset's zero never looks like an edge.
   always_comb begin
      w_debNext = r_deb;
      if (i_tick && (!i_primed || (r_sync2 == r_cand))) begin
         w_debNext = r_sync2;
      end
   end

   assign o_deb  = r_deb;
   assign o_rise = i_tick & i_primed &  w_debNext & ~r_deb;
   assign o_fall = i_tick & i_primed & ~w_debNext &  r_deb;

endmodule

// File: rtl/ladybird_gpio_ctrl.sv
// GPIO controller: debounced inputs with edge interrupts, set/clear outputs and
// a byte-lane register file on the ladybird bus.
module ladybird_gpio_ctrl
   import ladybird_gpio_pkg::*;
#(
   parameter int          N_IN            = 4,
   parameter int          N_OUT           = 4,
   parameter logic [15:0] SAMPLE_INTERVAL = 16'h364
) (
   input  logic             clk,
   input  logic             arst,
   ladybird_bus.secondary   bus,
   input  logic [N_IN-1:0]  GPIO_IN,
   output logic [N_OUT-1:0] GPIO_OUT,
   output logic             irq
);

   logic [15:0]               r_tickCnt;
   logic                      r_primed;
   logic                      w_tick;
   logic [N_OUT-1:0]          r_out;
   logic [N_IN-1:0]           r_riseEn;
   logic [N_IN-1:0]           r_fallEn;
   logic [N_IN-1:0]           r_status;
   logic                      r_irq;
   logic [N_IN-1:0]           w_deb;
   logic [N_IN-1:0]           w_rise;
   logic [N_IN-1:0]           w_fall;
   logic [N_IN-1:0]           w_statusSet;
   logic [N_IN-1:0]           w_statusClr;
   logic                      w_write;
   logic                      w_read;
   logic [4:0]                w_offset;
   logic [GPIO_MAX_WIDTH-1:0] w_byteMask;
   logic [GPIO_MAX_WIDTH-1:0] w_wdataMasked;
   logic [GPIO_MAX_WIDTH-1:0] w_rdata;
   logic                      w_unusedBits;

   assign w_write       = bus.req & (|bus.wstrb);
   assign w_read        = bus.req & ~(|bus.wstrb);
   assign w_offset      = bus.addr[4:0];
   assign w_byteMask    = strbToMask(bus.wstrb);
   assign w_wdataMasked = bus.wdata & w_byteMask;
   assign w_unusedBits  = ^{bus.addr[31:5], w_wdataMasked, w_byteMask};

   assign bus.gnt      = 1'b1;
   assign bus.data_gnt = w_read;
   assign bus.data     = w_read ? w_rdata : 'z;

   assign w_tick = (r_tickCnt == SAMPLE_INTERVAL);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_tickCnt <= '0;
         r_primed  <= 1'b0;
      end else begin
         r_tickCnt <= w_tick ? 16'd0 : r_tickCnt + 16'd1;
         if (w_tick) begin
            r_primed <= 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
      ladybird_gpio_debounce u_deb (
         .clk      (clk),
         .arst     (arst),
         .i_pin    (GPIO_IN[gi]),
         .i_tick   (w_tick),
         .i_primed (r_primed),
         .o_deb    (w_deb[gi]),
         .o_rise   (w_rise[gi]),
         .o_fall   (w_fall[gi])
      );
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_out <= '0;
      end else if (w_write) begin
         case (w_offset)
            ADDR_OUT:     r_out <= (r_out & ~w_byteMask[N_OUT-1:0]) | w_wdataMasked[N_OUT-1:0];
            ADDR_OUT_SET: r_out <= r_out | w_wdataMasked[N_OUT-1:0];
            ADDR_OUT_CLR: r_out <= r_out & ~w_wdataMasked[N_OUT-1:0];
            default:      r_out <= r_out;
         endcase
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_riseEn <= '0;
         r_fallEn <= '0;
      end else if (w_write) begin
         if (w_offset == ADDR_RISE_EN) begin
            r_riseEn <= (r_riseEn & ~w_byteMask[N_IN-1:0]) | w_wdataMasked[N_IN-1:0];
         end
         if (w_offset == ADDR_FALL_EN) begin
            r_fallEn <= (r_fallEn & ~w_byteMask[N_IN-1:0]) | w_wdataMasked[N_IN-1:0];
         end
      end
   end

   // A new edge wins over a clear landing on the same bit in the same cycle.
   assign w_statusSet = (w_rise & r_riseEn) | (w_fall & r_fallEn);
   assign w_statusClr = (w_write && (w_offset == ADDR_STATUS)) ? w_wdataMasked[N_IN-1:0] : '0;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_status <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_statusClr) | w_statusSet;
         r_irq    <= |r_status;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_offset)
         ADDR_IN:       w_rdata = 32'(w_deb);
         ADDR_OUT:      w_rdata = 32'(r_out);
         ADDR_RISE_EN:  w_rdata = 32'(r_riseEn);
         ADDR_FALL_EN:  w_rdata = 32'(r_fallEn);
         ADDR_STATUS:   w_rdata = 32'(r_status);
         ADDR_INTERVAL: w_rdata = 32'(SAMPLE_INTERVAL);
         default:       w_rdata = '0;
      endcase
   end

   assign GPIO_OUT = r_out;
   assign irq      = r_irq;

endmodule

// File: tb/tb_ladybird_gpio_ctrl.sv
// Directed bench for ladybird_gpio_ctrl: bus reads are scoreboarded by a
// negedge monitor, pin-level outputs are checked directly.
module tb_ladybird_gpio_ctrl;
   import ladybird_gpio_pkg::*;

   localparam int TICK_PERIOD = 32'h364 + 1;

   logic       clk = 1'b0;
   logic       arst;
   logic [3:0] gpioIn;
   logic [3:0] gpioOut;
   logic       irq;

   int          testsRun    = 0;
   int          testsFailed = 0;
   int          tickPhase;
   logic [31:0] expQ[$];
   string       nameQ[$];
   logic [31:0] monExp;
   string       monName;

   ladybird_bus bus ();

   ladybird_gpio_ctrl #(
      .N_IN            (4),
      .N_OUT           (4),
      .SAMPLE_INTERVAL (16'h364)
   ) dut (
      .clk      (clk),
      .arst     (arst),
      .bus      (bus),
      .GPIO_IN  (gpioIn),
      .GPIO_OUT (gpioOut),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   // Reference tick phase: the debounced state updates on the edge leaving phase TICK_PERIOD-1.
   always @(posedge clk or posedge arst) begin
      if (arst) tickPhase <= 0;
      else      tickPhase <= (tickPhase == TICK_PERIOD - 1) ? 0 : tickPhase + 1;
   end

   always @(negedge clk) begin
      if (bus.data_gnt === 1'b1) begin
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected_read actual=0x%0h required=no read", bus.data);
         end else begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            if (bus.data !== monExp) begin
               testsFailed++;
               $display("[TB] FAIL %s actual=0x%0h required=0x%0h", monName, bus.data, monExp);
            end
         end
      end
   end

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] pins);
      gpioIn = pins;
   endtask

   task automatic busWrite(input logic [4:0] off, input logic [31:0] data, input logic [3:0] strb);
      bus.req   = 1'b1;
      bus.addr  = {27'd0, off};
      bus.wdata = data;
      bus.wstrb = strb;
      @(posedge clk);
      #1;
      bus.req   = 1'b0;
      bus.wstrb = 4'd0;
   endtask

   task automatic busRead(input logic [4:0] off, input logic [31:0] exp, input string nm);
      expQ.push_back(exp);
      nameQ.push_back(nm);
      bus.req   = 1'b1;
      bus.addr  = {27'd0, off};
      bus.wstrb = 4'd0;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitPhase(input int phase, input string nm);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (tickPhase != phase && n < 2 * TICK_PERIOD);
      if (tickPhase != phase) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s actual=timeout required=phase %0d", nm, phase);
      end
   endtask

   task automatic syncToTick();
      waitPhase(0, "tick_wait");
   endtask

   initial begin
      arst      = 1'b1;
      bus.req   = 1'b0;
      bus.addr  = 32'd0;
      bus.wdata = 32'd0;
      bus.wstrb = 4'd0;
      applyStimulus(4'b1010);
      waitCycles(3);
      checkOutput("rst_gpio_out", 32'(gpioOut), 32'h0);
      checkOutput("rst_irq", 32'(irq), 32'h0);
      arst = 1'b0;
      checkOutput("gnt", 32'(bus.gnt), 32'h1);

      // Reset values and debounced inputs after two ticks
      busRead(ADDR_INTERVAL, 32'h364, "interval");
      busRead(ADDR_OUT, 32'h0, "rst_out");
      busRead(ADDR_STATUS, 32'h0, "rst_status");
      busRead(ADDR_RISE_EN, 32'h0, "rst_rise_en");
      syncToTick();
      checkOutput("irq_tick1", 32'(irq), 32'h0);
      syncToTick();
      busRead(ADDR_IN, 32'hA, "in_after_two_ticks");
      checkOutput("irq_tick2", 32'(irq), 32'h0);

      // Rising edge on pin0 with RISE_EN, then W1C
      busWrite(ADDR_RISE_EN, 32'h1, 4'hF);
      syncToTick();
      applyStimulus(4'b1011);
      syncToTick();
      busRead(ADDR_STATUS, 32'h0, "status_one_tick");
      syncToTick();
      checkOutput("irq_lags_status", 32'(irq), 32'h0);
      busRead(ADDR_STATUS, 32'h1, "status_rise");
      checkOutput("irq_set", 32'(irq), 32'h1);
      busRead(ADDR_IN, 32'hB, "in_pin0_high");
      busWrite(ADDR_STATUS, 32'h1, 4'hF);
      checkOutput("irq_hold_w1c", 32'(irq), 32'h1);
      busRead(ADDR_STATUS, 32'h0, "status_w1c");
      checkOutput("irq_clear", 32'(irq), 32'h0);

      // Glitch on pin1 spanning exactly one tick
      busWrite(ADDR_FALL_EN, 32'h2, 4'hF);
      syncToTick();
      waitCycles(700);
      applyStimulus(4'b1001);
      waitCycles(300);
      applyStimulus(4'b1011);
      syncToTick();
      syncToTick();
      busRead(ADDR_IN, 32'hB, "in_glitch");
      busRead(ADDR_STATUS, 32'h0, "status_glitch");
      checkOutput("irq_glitch", 32'(irq), 32'h0);

      // Output register, set/clear aliases and byte lanes
      busWrite(ADDR_OUT, 32'h5, 4'hF);
      checkOutput("out_write", 32'(gpioOut), 32'h5);
      busWrite(ADDR_OUT_SET, 32'h2, 4'hF);
      checkOutput("out_set", 32'(gpioOut), 32'h7);
      busWrite(ADDR_OUT_CLR, 32'h4, 4'hF);
      checkOutput("out_clr", 32'(gpioOut), 32'h3);
      busWrite(ADDR_OUT, 32'hFF, 4'b1110);
      checkOutput("out_lane0_off", 32'(gpioOut), 32'h3);
      busRead(ADDR_OUT, 32'h3, "out_readback");
      busWrite(ADDR_OUT, 32'hFFFF_FFF0, 4'hF);
      checkOutput("out_upper_bits", 32'(gpioOut), 32'h0);
      busWrite(ADDR_OUT, 32'hFFFF_FF0C, 4'b0001);
      checkOutput("out_lane0_only", 32'(gpioOut), 32'hC);
      busWrite(ADDR_RISE_EN, 32'hFFFF_FFF1, 4'hF);
      busRead(ADDR_RISE_EN, 32'h1, "rise_en_width");

      // W1C landing on the same edge as a new rise on bit0
      busWrite(ADDR_FALL_EN, 32'h3, 4'hF);
      syncToTick();
      applyStimulus(4'b1010);
      syncToTick();
      syncToTick();
      busRead(ADDR_STATUS, 32'h1, "status_fall0");
      applyStimulus(4'b1011);
      syncToTick();
      waitPhase(TICK_PERIOD - 1, "pre_tick_wait");
      busWrite(ADDR_STATUS, 32'h1, 4'hF);
      busRead(ADDR_STATUS, 32'h1, "status_w1c_vs_set");
      checkOutput("irq_w1c_vs_set", 32'(irq), 32'h1);
      busWrite(ADDR_STATUS, 32'h1, 4'hF);
      busRead(ADDR_STATUS, 32'h0, "status_cleared");

      // Reset mid-write with STATUS set and an edge pending
      syncToTick();
      applyStimulus(4'b1001);
      syncToTick();
      syncToTick();
      busRead(ADDR_STATUS, 32'h2, "status_fall1");
      checkOutput("irq_pre_reset", 32'(irq), 32'h1);
      applyStimulus(4'b1011);
      syncToTick();
      bus.req   = 1'b1;
      bus.addr  = {27'd0, ADDR_OUT};
      bus.wdata = 32'hF;
      bus.wstrb = 4'hF;
      #2;
      arst = 1'b1;
      #1;
      checkOutput("async_rst_gpio_out", 32'(gpioOut), 32'h0);
      checkOutput("async_rst_irq", 32'(irq), 32'h0);
      waitCycles(1);
      bus.req   = 1'b0;
      bus.wstrb = 4'd0;
      waitCycles(2);
      arst = 1'b0;
      busWrite(ADDR_RISE_EN, 32'hF, 4'hF);
      busWrite(ADDR_FALL_EN, 32'hF, 4'hF);
      syncToTick();
      busRead(ADDR_STATUS, 32'h0, "status_prime_tick");
      checkOutput("irq_prime_tick", 32'(irq), 32'h0);
      busRead(ADDR_IN, 32'hB, "in_prime_tick");
      busRead(ADDR_OUT, 32'h0, "out_after_rst");
      checkOutput("gpio_out_after_rst", 32'(gpioOut), 32'h0);
      syncToTick();
      busRead(ADDR_STATUS, 32'h0, "status_second_tick");
      checkOutput("irq_second_tick", 32'(irq), 32'h0);

      waitCycles(2);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ladybird_gpio_ctrl.md
LADYBIRD_GPIO_CTRL -- requirements
Module: ladybird_gpio_ctrl

Interface
REQ-001 Parameter N_IN, default 4, number of input pins, range 1..32, SHALL be honoured.
REQ-002 Parameter N_OUT, default 4, number of output pins, range 1..32, SHALL be honoured.
REQ-003 Parameter SAMPLE_INTERVAL, 16-bit, default 16'h364, sets the sample-tick period in clk cycles and SHALL be honoured.
REQ-004 Port clk, input, 1, is the single clock; every flop SHALL be clocked by its rising edge.
REQ-005 Port arst, input, 1, SHALL be an asynchronous, active-high reset.
REQ-006 Port bus, ladybird_bus.secondary, -, SHALL be the register access port.
REQ-007 Port GPIO_IN, input, N_IN, SHALL carry the raw asynchronous pins.
REQ-008 Port GPIO_OUT, output, N_OUT, SHALL drive the output pins.
REQ-009 Port irq, output, 1, SHALL be the level interrupt output.

Function
REQ-010 The block SHALL drive bus.gnt to 1 at all times.
- Write: bus.req & |bus.wstrb.
- Read: bus.req & ~|bus.wstrb; bus.data_gnt = read; bus.data driven combinationally with read data in the same cycle, else 'z.
REQ-011 The address map SHALL be decoded on bus.addr[4:0]; unmapped reads return 0 and unmapped writes are ignored.
- 0x00 IN (RO, debounced inputs)
- 0x04 OUT (RW)
- 0x08 OUT_SET (WO, write-1-sets)
- 0x0C OUT_CLR (WO, write-1-clears)
- 0x10 RISE_EN
- 0x14 FALL_EN
- 0x18 STATUS (RW1C)
- 0x1C INTERVAL (RO, SAMPLE_INTERVAL)
REQ-012 Writes SHALL honour byte lanes: register byte k updates only when wstrb[k]=1.
REQ-013 Register bits at or above N_IN or N_OUT SHALL read 0 and ignore writes.
REQ-014 Each GPIO_IN bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 A free-running 16-bit tick counter SHALL assert tick for one cycle when it equals SAMPLE_INTERVAL and then wrap to 0.
REQ-016 On each tick, per bit:
- cand <= sync.
- If sync == cand, deb <= sync, so a level must be stable across two consecutive ticks.
REQ-017 Edge flags SHALL be computed from the deb update:
- rise = deb_next & ~deb
- fall = ~deb_next & deb
REQ-018 STATUS bit i SHALL set on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
REQ-019 A same-cycle STATUS W1C and set on the same bit SHALL leave the bit set.
REQ-020 irq SHALL equal |STATUS, registered, asserting one cycle after the status bit sets.
REQ-021 OUT_SET and OUT_CLR SHALL update OUT on the cycle after the write; a 1 in both is impossible since they are separate addresses.
REQ-022 GPIO_OUT SHALL equal the OUT register.
REQ-023 Until a primed flag is set, deb SHALL load sync at a tick with no edges generated; primed SHALL set on the first tick after reset.

Reset
REQ-024 On arst, the following SHALL clear to 0: OUT, GPIO_OUT, RISE_EN, FALL_EN, STATUS, irq, deb, cand, sync, tick counter, and primed.
REQ-025 Reset asserted mid-operation SHALL clear the block immediately and discard any pending edges.
REQ-026 After reset release, no interrupt SHALL fire before the second tick.

Structure
REQ-027 Package ladybird_gpio_pkg SHALL hold the register offset localparams and a max-width constant (32).
REQ-028 Sub-module ladybird_gpio_debounce SHALL hold one bit of synchroniser, cand, deb, and the rise/fall logic; it SHALL be instantiated N_IN times via generate and share a single tick.
REQ-029 The tick counter and register file SHALL reside in ladybird_gpio_ctrl.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, then read 0x1C -> 0x364; read 0x00 after two ticks with GPIO_IN=4'b1010 -> 0xA; irq=0 throughout.
- RISE_EN=0x1, pin0 0->1 held for 2 ticks -> STATUS=0x1, irq high 1 cycle later; W1C 0x1 to 0x18 -> STATUS=0, irq low next cycle.
- Glitch on pin1 lasting less than one interval with FALL_EN=0x2 -> IN unchanged, STATUS stays 0.
- Write OUT=0x5, OUT_SET=0x2, OUT_CLR=0x4 -> GPIO_OUT 0x5, 0x7, 0x3 on successive cycles; write with wstrb=0 lane 0 -> no change.
- W1C on the same cycle as a new edge on that bit -> bit remains 1.
- arst asserted mid-write and while STATUS≠0 -> all outputs 0 asynchronously; no edge reported on the first tick after release.
